// File: rtl/sram_bridge.sv
// CPU-side initiator for a 16-bit asynchronous SRAM: turns one byte/half/word
// load or store into one or two strobed half accesses with programmable wait states.
module sram_bridge #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [18:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic        busy,
  output logic [17:0] addr,
  inout  wire  [15:0] data,
  output logic        wre,
  output logic        oute,
  output logic        hb_mask,
  output logic        lb_mask,
  output logic        chip_en
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ACC_LO, REC_LO, ACC_HI, REC_HI, DONE, ERR
  } state_t;

  state_t        state, state_d;
  logic          we_q, signed_q, bsel_q;
  logic [1:0]    size_q;
  logic [31:0]   wdata_q;
  logic [17:0]   addr_q;
  logic [CW-1:0] cnt;
  logic [15:0]   lo_q, hi_q;

  logic          req_bad, cnt_last, in_acc, in_bus, hi_half, drive;
  logic [15:0]   wlane;
  logic [7:0]    load_byte;
  logic [31:0]   load_val;

  always_comb begin
    case (cpu_size)
      SZ_BYTE: req_bad = 1'b0;
      SZ_HALF: req_bad = cpu_addr[0];
      SZ_WORD: req_bad = |cpu_addr[1:0];
      default: req_bad = 1'b1;
    endcase
  end

  assign cnt_last = (cnt == CNT_LAST);
  assign in_acc   = (state == ACC_LO) || (state == ACC_HI);
  assign in_bus   = in_acc || (state == REC_LO) || (state == REC_HI);
  assign hi_half  = (state == ACC_HI) || (state == REC_HI);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (cpu_req) state_d = req_bad ? ERR : ACC_LO;
      ACC_LO:  if (cnt_last) state_d = REC_LO;
      REC_LO:  state_d = (size_q == SZ_WORD) ? ACC_HI : DONE;
      ACC_HI:  if (cnt_last) state_d = REC_HI;
      REC_HI:  state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    chip_en = ~in_bus;
    oute    = ~(in_acc && !we_q);
    wre     = ~(in_acc && we_q);
    hb_mask = ~(in_bus && ((size_q != SZ_BYTE) || bsel_q));
    lb_mask = ~(in_bus && ((size_q != SZ_BYTE) || !bsel_q));
    cpu_ack = (state == DONE);
    cpu_err = (state == ERR);
    busy    = (state != IDLE);
    drive   = in_bus && we_q;
  end

  // Byte stores replicate the byte on both lanes; the masks pick the lane.
  always_comb begin
    if (hi_half)                 wlane = wdata_q[31:16];
    else if (size_q == SZ_BYTE)  wlane = {2{wdata_q[7:0]}};
    else                         wlane = wdata_q[15:0];
  end

  assign data = drive ? wlane : 16'hzzzz;
  assign addr = addr_q;

  always_comb begin
    load_byte = bsel_q ? lo_q[15:8] : lo_q[7:0];
    case (size_q)
      SZ_BYTE: load_val = {{24{signed_q & load_byte[7]}}, load_byte};
      SZ_HALF: load_val = {{16{signed_q & lo_q[15]}}, lo_q};
      default: load_val = {hi_q, lo_q};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q      <= 1'b0;
      signed_q  <= 1'b0;
      bsel_q    <= 1'b0;
      size_q    <= SZ_BYTE;
      wdata_q   <= '0;
      addr_q    <= '0;
      cnt       <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      cpu_rdata <= '0;
    end else begin
      if (state == IDLE && cpu_req && !req_bad) begin
        we_q     <= cpu_we;
        signed_q <= cpu_signed;
        bsel_q   <= cpu_addr[0];
        size_q   <= cpu_size;
        wdata_q  <= cpu_wdata;
        addr_q   <= cpu_addr[18:1];
      end
      // Upper half of a word sits at the next halfword, wrapping at the top of the array.
      if (state == REC_LO && size_q == SZ_WORD) addr_q <= addr_q + 1'b1;

      if (in_acc && !cnt_last) cnt <= cnt + 1'b1;
      else                     cnt <= '0;

      if (state == ACC_LO && cnt_last && !we_q) lo_q <= data;
      if (state == ACC_HI && cnt_last && !we_q) hi_q <= data;

      if ((state == REC_LO || state == REC_HI) && state_d == DONE && !we_q) cpu_rdata <= load_val;
    end
  end

endmodule

// File: tb/tb_sram_bridge.sv
// Scoreboard bench: two bridges (1 and 3 wait states) share the CPU stimulus,
// each with its own SRAM model, response monitor and bus statistics.
module tb_sram_bridge;

  localparam int NI = 2;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    int ce, oe, we, rec, bsy, hb, lb, hold_bad, run_bad, nacc;
  } stat_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_signed = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic [18:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;

  wire [31:0]    rdata [NI];
  wire [17:0]    addr  [NI];
  wire [NI-1:0]  ack, err, busy, wre, oute, hbm, lbm, ce;

  logic [15:0]   mem [NI][0:262143];
  exp_t          exp_q [NI][$];
  logic [17:0]   acc_log [NI][$];
  stat_t         st  [NI];
  stat_t         st0 [NI];

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_rd = '0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int W = (g == 0) ? 1 : 3;
    wire [15:0]  bus;
    int          run = 0;
    logic [17:0] last_a = '0;

    assign bus = (!ce[g] && !oute[g] && wre[g]) ? mem[g][addr[g]] : 16'hzzzz;

    sram_bridge #(.WAIT_CYCLES(W)) dut (
      .clock      (clock),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_size   (cpu_size),
      .cpu_signed (cpu_signed),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (rdata[g]),
      .cpu_ack    (ack[g]),
      .cpu_err    (err[g]),
      .busy       (busy[g]),
      .addr       (addr[g]),
      .data       (bus),
      .wre        (wre[g]),
      .oute       (oute[g]),
      .hb_mask    (hbm[g]),
      .lb_mask    (lbm[g]),
      .chip_en    (ce[g])
    );

    always @(negedge clock) begin : model
      exp_t e;
      if (reset) begin
        run = 0;
      end else begin
        if (!ce[g] && !wre[g]) begin
          if (!hbm[g]) mem[g][addr[g]][15:8] = bus[15:8];
          if (!lbm[g]) mem[g][addr[g]][7:0]  = bus[7:0];
        end
        if (!ce[g]) st[g].ce++;
        if (!oute[g]) st[g].oe++;
        if (!wre[g]) st[g].we++;
        if (busy[g]) st[g].bsy++;
        if (!hbm[g]) st[g].hb++;
        if (!lbm[g]) st[g].lb++;
        if (!oute[g] || !wre[g]) begin
          run++;
          if (run == 1) begin
            acc_log[g].push_back(addr[g]);
            st[g].nacc++;
            last_a = addr[g];
          end else if (addr[g] != last_a) begin
            st[g].hold_bad++;
          end
        end else begin
          if (run != 0 && run != W) st[g].run_bad++;
          run = 0;
          if (!ce[g]) begin
            st[g].rec++;
            if (addr[g] != last_a) st[g].hold_bad++;
          end
        end

        if (ack[g] || err[g]) begin
          if (exp_q[g].size() == 0) begin
            check($sformatf("d%0d_spurious_resp", g), 32'({ack[g], err[g]}), 32'h0);
          end else begin
            e = exp_q[g].pop_front();
            check($sformatf("d%0d_resp_err", g), 32'(err[g]), 32'(e.err));
            check($sformatf("d%0d_resp_ack", g), 32'(ack[g]), 32'(!e.err));
            check($sformatf("d%0d_resp_rdata", g), rdata[g], e.rdata);
            check($sformatf("d%0d_resp_latency", g), 32'(cyc - e.acc), 32'(e.lat));
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy != '0 || exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check("idle_timeout", 32'(n), 32'(0));
  endtask

  // Issue one request on both bridges; bad marks a request that must end in cpu_err.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [18:0] a, input logic [31:0] wd,
                       input logic bad, input logic [31:0] ld, input int hold = 1);
    exp_t e;
    if (!we && !bad) exp_rd = ld;
    for (int g = 0; g < NI; g++) begin
      int w = (g == 0) ? 1 : 3;
      e.err   = bad;
      e.rdata = exp_rd;
      e.acc   = cyc;
      e.lat   = bad ? 1 : ((sz == 2'b10) ? 2 * (w + 1) + 1 : w + 2);
      exp_q[g].push_back(e);
    end
    st0 = st;
    cpu_we = we; cpu_size = sz; cpu_signed = sgn; cpu_addr = a; cpu_wdata = wd;
    cpu_req = 1'b1;
    repeat (hold) @(negedge clock);
    cpu_req = 1'b0;
    cpu_we = ~we; cpu_size = ~sz; cpu_signed = ~sgn; cpu_addr = ~a; cpu_wdata = ~wd;
    wait_idle();
    for (int g = 0; g < NI; g++) begin
      int w = (g == 0) ? 1 : 3;
      int halves = bad ? 0 : ((sz == 2'b10) ? 2 : 1);
      int hb_exp, lb_exp;
      hb_exp = (!bad && sz == 2'b00) ? (a[0] ? w + 1 : 0) : halves * (w + 1);
      lb_exp = (!bad && sz == 2'b00) ? (a[0] ? 0 : w + 1) : halves * (w + 1);
      check($sformatf("d%0d_ce_cycles", g), 32'(st[g].ce - st0[g].ce), 32'(halves * (w + 1)));
      check($sformatf("d%0d_oe_cycles", g), 32'(st[g].oe - st0[g].oe), 32'(we ? 0 : halves * w));
      check($sformatf("d%0d_we_cycles", g), 32'(st[g].we - st0[g].we), 32'(we ? halves * w : 0));
      check($sformatf("d%0d_rec_cycles", g), 32'(st[g].rec - st0[g].rec), 32'(halves));
      check($sformatf("d%0d_accesses", g), 32'(st[g].nacc - st0[g].nacc), 32'(halves));
      check($sformatf("d%0d_busy_cycles", g), 32'(st[g].bsy - st0[g].bsy),
            32'(bad ? 1 : ((sz == 2'b10) ? 2 * (w + 1) + 1 : w + 2)));
      check($sformatf("d%0d_hb_cycles", g), 32'(st[g].hb - st0[g].hb), 32'(hb_exp));
      check($sformatf("d%0d_lb_cycles", g), 32'(st[g].lb - st0[g].lb), 32'(lb_exp));
      check($sformatf("d%0d_strobe_len", g), 32'(st[g].run_bad - st0[g].run_bad), 32'(0));
      check($sformatf("d%0d_addr_hold", g), 32'(st[g].hold_bad - st0[g].hold_bad), 32'(0));
    end
  endtask

  task automatic chk_mem(input string name, input logic [17:0] a, input logic [15:0] v);
    for (int g = 0; g < NI; g++)
      check($sformatf("d%0d_%s", g, name), 32'(mem[g][a]), 32'(v));
  endtask

  task automatic chk_acc(input string name, input int k, input logic [17:0] a);
    for (int g = 0; g < NI; g++)
      check($sformatf("d%0d_%s", g, name), 32'(acc_log[g][st0[g].nacc + k]), 32'(a));
  endtask

  initial begin
    repeat (3) @(negedge clock);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("d%0d_rst_ctrl", g), 32'({wre[g], oute[g], hbm[g], lbm[g], ce[g]}), 32'h1F);
      check($sformatf("d%0d_rst_addr", g), 32'(addr[g]), 32'h0);
      check($sformatf("d%0d_rst_rdata", g), rdata[g], 32'h0);
      check($sformatf("d%0d_rst_flags", g), 32'({ack[g], err[g], busy[g]}), 32'h0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);

    issue(1'b1, 2'b01, 1'b0, 19'h00020, 32'hABCD1234, 1'b0, 32'h0);
    chk_mem("half_store", 18'h10, 16'h1234);

    issue(1'b1, 2'b10, 1'b0, 19'h00010, 32'hDEADBEEF, 1'b0, 32'h0);
    chk_mem("word_store_lo", 18'h8, 16'hBEEF);
    chk_mem("word_store_hi", 18'h9, 16'hDEAD);
    chk_acc("word_store_a0", 0, 18'h8);
    chk_acc("word_store_a1", 1, 18'h9);

    issue(1'b0, 2'b10, 1'b0, 19'h00010, 32'h0, 1'b0, 32'hDEADBEEF);

    issue(1'b1, 2'b00, 1'b0, 19'h00021, 32'h12345680, 1'b0, 32'h0);
    chk_mem("byte_store_hi_lane", 18'h10, 16'h8034);

    issue(1'b0, 2'b00, 1'b1, 19'h00021, 32'h0, 1'b0, 32'hFFFFFF80);
    issue(1'b0, 2'b00, 1'b0, 19'h00021, 32'h0, 1'b0, 32'h00000080);
    issue(1'b0, 2'b00, 1'b0, 19'h00020, 32'h0, 1'b0, 32'h00000034);
    issue(1'b0, 2'b00, 1'b1, 19'h00020, 32'h0, 1'b0, 32'h00000034);
    issue(1'b0, 2'b01, 1'b1, 19'h00020, 32'h0, 1'b0, 32'hFFFF8034);
    issue(1'b0, 2'b01, 1'b0, 19'h00020, 32'h0, 1'b0, 32'h00008034);

    issue(1'b0, 2'b01, 1'b0, 19'h00003, 32'h0, 1'b1, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 19'h00002, 32'h0, 1'b1, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 19'h00000, 32'h0, 1'b1, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 19'h00021, 32'h5555AAAA, 1'b1, 32'h0);
    chk_mem("err_no_write", 18'h10, 16'h8034);

    issue(1'b1, 2'b10, 1'b0, 19'h7FFFC, 32'hCAFEF00D, 1'b0, 32'h0);
    chk_mem("top_word_lo", 18'h3FFFE, 16'hF00D);
    chk_mem("top_word_hi", 18'h3FFFF, 16'hCAFE);
    chk_acc("top_word_a0", 0, 18'h3FFFE);
    chk_acc("top_word_a1", 1, 18'h3FFFF);
    issue(1'b0, 2'b10, 1'b0, 19'h7FFFC, 32'h0, 1'b0, 32'hCAFEF00D);
    issue(1'b0, 2'b01, 1'b0, 19'h7FFFE, 32'h0, 1'b0, 32'h0000CAFE);
    chk_acc("top_half_a0", 0, 18'h3FFFF);

    issue(1'b0, 2'b01, 1'b1, 19'h00010, 32'h0, 1'b0, 32'hFFFFBEEF, 3);
    repeat (4) @(negedge clock);

    cpu_we = 1'b1; cpu_size = 2'b10; cpu_signed = 1'b0;
    cpu_addr = 19'h00040; cpu_wdata = 32'h11112222; cpu_req = 1'b1;
    @(negedge clock);
    cpu_req = 1'b0;
    repeat (2) @(negedge clock);
    check("d0_pre_reset_wre", 32'(wre[0]), 32'h0);
    check("d0_pre_reset_addr", 32'(addr[0]), 32'h21);
    #1 reset = 1'b1;
    #1;
    exp_rd = '0;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("d%0d_async_rst_ctrl", g), 32'({wre[g], oute[g], hbm[g], lbm[g], ce[g]}), 32'h1F);
      check($sformatf("d%0d_async_rst_busy", g), 32'(busy[g]), 32'h0);
      check($sformatf("d%0d_async_rst_addr", g), 32'(addr[g]), 32'h0);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    issue(1'b0, 2'b10, 1'b0, 19'h00010, 32'h0, 1'b0, 32'hDEADBEEF);

    repeat (5) @(negedge clock);
    for (int g = 0; g < NI; g++)
      check($sformatf("d%0d_leftover_expected", g), 32'(exp_q[g].size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
